fetch_sequencer: RTL and testbench

//  Instruction-fetch controller sequencing the program counter against a

---
 rtl/fetch_sequencer.sv | 139 +++++++++++++
 tb/tb_fetch_sequencer.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: walks the PC against a valid/ready instruction
// memory, buffers one word under decode backpressure, and applies taken-branch redirects.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        br_valid,
  input  logic        br_zero,
  input  logic        br_minus,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_imm,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // PC-relative target; the offset is a signed word count and the sum wraps mod 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic signed [31:0] off);
    branch_target = pc + $unsigned(off);
  endfunction

  logic [1:0]         state;
  logic [31:0]        pc;
  logic               kill;
  logic [31:0]        pend_instr;
  logic [31:0]        pend_pc;
  logic signed [31:0] br_off;
  logic               taken;
  logic [31:0]        target;
  logic               xfer;
  logic               can_load;
  logic               rsp_live;

  assign br_off   = $signed(br_imm);
  assign taken    = br_valid & (br_zero | br_minus);
  assign target   = branch_target(br_pc, br_off);
  assign xfer     = if_valid & if_ready;
  assign can_load = ~if_valid | if_ready;
  assign rsp_live = (state == ST_WAIT) & imem_rvalid & ~kill;

  assign imem_req  = (state == ST_REQ);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      kill     <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else if (taken) begin
      // Redirect wins: the address may only change once the request line is low,
      // so an unaccepted request is withdrawn via IDLE and an accepted one is killed.
      pc       <= target;
      if_valid <= 1'b0;
      case (state)
        ST_REQ: begin
          if (imem_ready) begin
            state <= ST_WAIT;
            kill  <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            state <= ST_IDLE;
            kill  <= 1'b0;
          end else begin
            kill  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end else begin
      if (xfer) begin
        if_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: state <= ST_REQ;
        ST_REQ: begin
          if (imem_ready) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= ST_REQ;
            end else begin
              pc <= pc + 32'd1;
              if (can_load) begin
                if_valid <= 1'b1;
                if_instr <= imem_rdata;
                if_pc    <= pc;
                state    <= ST_REQ;
              end else begin
                state    <= ST_HOLD;
              end
            end
          end
        end
        ST_HOLD: begin
          if (if_ready) begin
            if_valid <= 1'b1;
            if_instr <= pend_instr;
            if_pc    <= pend_pc;
            state    <= ST_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Skid word: only meaningful while in HOLD, so it carries no reset.
  always_ff @(posedge clk) begin
    if (rsp_live && !can_load) begin
      pend_instr <= imem_rdata;
      pend_pc    <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized
// traffic scored against a queue-based model of the delivered instruction stream.
`timescale 1ns/1ps
module tb_fetch_sequencer;
  localparam logic [31:0] RESET_PC = 32'h1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        br_valid = 1'b0;
  logic        br_zero = 1'b0;
  logic        br_minus = 1'b0;
  logic [31:0] br_pc = '0;
  logic [31:0] br_imm = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready = 1'b1;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .br_valid(br_valid), .br_zero(br_zero), .br_minus(br_minus),
    .br_pc(br_pc), .br_imm(br_imm),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready)
  );

  int errors = 0;
  int checks = 0;

  // Memory and stimulus knobs
  int          rdy_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          rand_ifr = 1'b0;
  bit          rand_br = 1'b0;
  int          ifr_pct = 70;
  int          br_pct = 8;
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr_l = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Advance one cycle: memory answers accepted requests after a random latency,
  // new inputs are applied 1ns after the rising edge.
  task automatic step();
    if (rst && imem_req && imem_ready) begin
      mem_busy   = 1'b1;
      mem_addr_l = imem_addr;
      mem_cnt    = int'($urandom_range(lat_max, lat_min));
    end else if (imem_rvalid) begin
      mem_busy = 1'b0;
    end
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_busy && rst) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr_l);
      end
    end
    imem_ready = (int'($urandom_range(99, 0)) < rdy_pct);
    if (rand_ifr) if_ready = (int'($urandom_range(99, 0)) < ifr_pct);
    br_valid = 1'b0;
    br_zero  = 1'($urandom);
    br_minus = 1'($urandom);
    br_pc    = $urandom;
    br_imm   = 32'($urandom_range(20, 0)) - 32'd10;
    if (rand_br && int'($urandom_range(99, 0)) < br_pct) br_valid = 1'b1;
  endtask

  // Reference model: queue of PCs that decode still has to receive, next
  // expected fetch address, and the fate of the one outstanding request.
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch = RESET_PC;
  logic [31:0] out_addr = '0;
  logic [31:0] held_addr = '0;
  bit          out_live = 1'b0;
  bit          out_wrong = 1'b0;
  bit          held_v = 1'b0;
  bit          taken_m = 1'b0;
  int          xfer_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      exp_fetch = RESET_PC;
      out_live  = 1'b0;
      out_wrong = 1'b0;
      held_v    = 1'b0;
    end else begin
      checks++;
      if (if_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL mon_if_valid: got %b want %0d (t=%0t)", if_valid, exp_q.size() != 0, $time);
      end
      if (if_valid === 1'b1 && exp_q.size() != 0) begin
        checks++;
        if (if_pc !== exp_q[0] || if_instr !== mem_word(exp_q[0])) begin
          errors++;
          $display("FAIL mon_if_data: got pc=%h instr=%h want pc=%h instr=%h", if_pc, if_instr,
                   exp_q[0], mem_word(exp_q[0]));
        end
      end
      if (out_live) begin
        checks++;
        if (imem_req !== 1'b0) begin
          errors++;
          $display("FAIL mon_one_outstanding: got imem_req=%b want 0", imem_req);
        end
      end
      if (exp_q.size() >= 2) begin
        checks++;
        if (imem_req !== 1'b0 || exp_q.size() > 2) begin
          errors++;
          $display("FAIL mon_hold: got imem_req=%b depth=%0d want 0 depth<=2", imem_req, exp_q.size());
        end
      end
      if (held_v && imem_req === 1'b1) begin
        checks++;
        if (imem_addr !== held_addr) begin
          errors++;
          $display("FAIL mon_addr_stable: got %h want %h", imem_addr, held_addr);
        end
      end
      // Predict the coming edge
      taken_m = br_valid && (br_zero || br_minus);
      if (if_valid && if_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        xfer_cnt++;
      end
      held_v    = imem_req && !imem_ready;
      held_addr = imem_addr;
      if (imem_req && imem_ready) begin
        checks++;
        if (imem_addr !== exp_fetch) begin
          errors++;
          $display("FAIL mon_fetch_addr: got %h want %h", imem_addr, exp_fetch);
        end
        out_live  = 1'b1;
        out_wrong = 1'b0;
        out_addr  = imem_addr;
      end else if (imem_rvalid && out_live) begin
        if (!out_wrong && !taken_m) begin
          exp_q.push_back(out_addr);
          exp_fetch = out_addr + 32'd1;
        end
        out_live = 1'b0;
      end
      if (taken_m) begin
        exp_fetch = br_pc + br_imm;
        exp_q.delete();
        if (out_live) out_wrong = 1'b1;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0; if_ready = 1'b1; imem_ready = 1'b1; br_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_if_instr: got %h want 0", if_instr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc: got %h want 0", if_pc); end
  endtask

  task automatic test_sequential();
    bit exp_v;
    rdy_pct = 100; lat_min = 1; lat_max = 1; if_ready = 1'b1; mem_busy = 1'b0;
    rst = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i % 2 == 1) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'((i + 1) / 2)) begin
          errors++;
          $display("FAIL seq_addr%0d: got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, 32'((i + 1) / 2));
        end
      end
      exp_v = (i >= 3) && (i % 2 == 1);
      checks++;
      if (if_valid !== exp_v) begin
        errors++;
        $display("FAIL seq_valid%0d: got %b want %b", i, if_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (if_pc !== 32'((i - 1) / 2) || if_instr !== mem_word(32'((i - 1) / 2))) begin
          errors++;
          $display("FAIL seq_data%0d: got pc=%h instr=%h want pc=%h", i, if_pc, if_instr, 32'((i - 1) / 2));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] p;
    int n = 0;
    while (if_valid !== 1'b1 && n < 20) begin step(); n++; end
    p = if_pc;
    if_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== p || if_instr !== mem_word(p) || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b pc=%h req=%b want v=1 pc=%h req=0", i, if_valid, if_pc, imem_req, p);
      end
    end
    if_ready = 1'b1;
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== p + 32'd1 || if_instr !== mem_word(p + 32'd1)) begin
      errors++;
      $display("FAIL bp_pending: got v=%b pc=%h want v=1 pc=%h", if_valid, if_pc, p + 32'd1);
    end
    step(); step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== p + 32'd2) begin
      errors++;
      $display("FAIL bp_resume: got v=%b pc=%h want v=1 pc=%h", if_valid, if_pc, p + 32'd2);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] p;
    int cnt = 0;
    int n = 0;
    while (if_valid !== 1'b1 && n < 20) begin step(); n++; end
    p = if_pc;
    for (int i = 0; i < 40; i++) begin
      step();
      if (if_valid === 1'b1) begin
        cnt++;
        checks++;
        if (if_pc !== p + 32'(cnt)) begin
          errors++;
          $display("FAIL b2b_pc: got %h want %h", if_pc, p + 32'(cnt));
        end
      end
    end
    checks++;
    if (cnt != 20) begin errors++; $display("FAIL b2b_rate: got %0d want 20", cnt); end
  endtask

  task automatic test_branch_taken();
    int n;
    // Redirect while the response is still outstanding
    lat_min = 3; lat_max = 3;
    n = 0;
    while (!(imem_req === 1'b1 && imem_ready === 1'b1) && n < 20) begin step(); n++; end
    step();
    br_valid = 1'b1; br_zero = 1'b1; br_minus = 1'b0; br_pc = 32'd8; br_imm = 32'hFFFFFFFD;
    step();
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL br_flush: got v=%b req=%b want v=0 req=0", if_valid, imem_req);
    end
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd5) begin
      errors++;
      $display("FAIL br_addr: got req=%b addr=%h want req=1 addr=5", imem_req, imem_addr);
    end
    n = 0;
    while (if_valid !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'd5 || if_instr !== mem_word(32'd5)) begin
      errors++;
      $display("FAIL br_pc: got v=%b pc=%h want v=1 pc=5", if_valid, if_pc);
    end
    // Redirect in the same cycle the response arrives
    lat_min = 1; lat_max = 1;
    n = 0;
    while (!(imem_req === 1'b1 && imem_ready === 1'b1) && n < 20) begin step(); n++; end
    step();
    br_valid = 1'b1; br_zero = 1'b1; br_minus = 1'b1; br_pc = 32'd40; br_imm = 32'd3;
    n = 0;
    do begin step(); n++; end while (imem_req !== 1'b1 && n < 20);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd43) begin
      errors++;
      $display("FAIL br_rsp_addr: got req=%b addr=%h want req=1 addr=2b", imem_req, imem_addr);
    end
    n = 0;
    while (if_valid !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'd43) begin
      errors++;
      $display("FAIL br_rsp_pc: got v=%b pc=%h want v=1 pc=2b", if_valid, if_pc);
    end
  endtask

  task automatic test_branch_not_taken();
    logic [31:0] a;
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin step(); n++; end
    a = imem_addr;
    br_valid = 1'b1; br_zero = 1'b0; br_minus = 1'b0; br_pc = 32'd100; br_imm = 32'd50;
    n = 0;
    do begin step(); n++; end while (if_valid !== 1'b1 && n < 20);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== a) begin
      errors++;
      $display("FAIL nt_pc: got v=%b pc=%h want v=1 pc=%h", if_valid, if_pc, a);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== a + 32'd1) begin
      errors++;
      $display("FAIL nt_addr: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, a + 32'd1);
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin step(); n++; end
    br_valid = 1'b1; br_zero = 1'b0; br_minus = 1'b1; br_pc = 32'hFFFFFFFF; br_imm = 32'd2;
    n = 0;
    do begin step(); n++; end while (imem_req !== 1'b1 && n < 20);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd1) begin
      errors++;
      $display("FAIL wrap_addr: got req=%b addr=%h want req=1 addr=1", imem_req, imem_addr);
    end
    n = 0;
    while (if_valid !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'd1) begin
      errors++;
      $display("FAIL wrap_pc: got v=%b pc=%h want v=1 pc=1", if_valid, if_pc);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    lat_min = 3; lat_max = 3;
    while (!(imem_req === 1'b1 && imem_ready === 1'b1) && n < 20) begin step(); n++; end
    step();
    #2;
    rst = 1'b0;
    mem_busy = 1'b0; imem_rvalid = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== RESET_PC || if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: got req=%b addr=%h v=%b instr=%h pc=%h want 0/%h/0/0/0",
               imem_req, imem_addr, if_valid, if_instr, if_pc, RESET_PC);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL rstmid_restart: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
    n = 0;
    while (if_valid !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (if_valid !== 1'b1 || if_pc !== RESET_PC) begin
      errors++;
      $display("FAIL rstmid_first: got v=%b pc=%h want v=1 pc=%h", if_valid, if_pc, RESET_PC);
    end
  endtask

  task automatic test_random();
    int x0 = xfer_cnt;
    rdy_pct = 60; lat_min = 1; lat_max = 3; rand_ifr = 1'b1; rand_br = 1'b1;
    for (int i = 0; i < 3000; i++) step();
    rand_ifr = 1'b0; rand_br = 1'b0; if_ready = 1'b1; rdy_pct = 100;
    checks++;
    if (xfer_cnt - x0 < 100) begin
      errors++;
      $display("FAIL rand_progress: got %0d transfers want >=100", xfer_cnt - x0);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_back_to_back();
    test_branch_taken();
    test_branch_not_taken();
    test_wrap();
    test_reset_mid();
    test_random();
    repeat (4) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
